// File: rtl/i2c_pin_conditioner.sv
// I2C pad-side front end: synchronise and debounce SCL/SDA, delay SCL toward
// the core, emit edge/START/STOP strobes, and hold-delay the SDA pad drive.

// One pad line: two-flop synchroniser followed by a length-programmable debounce.
module i2c_pin_conditioner_line #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] len_i,
    input  logic             pad_i,
    output logic             filt_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             s1_q, s2_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    // Accept a new level only after it has differed from filt for len+1 samples.
    always_comb begin
        filt_d = filt_q;
        dcnt_d = dcnt_q;
        if (s2_q == filt_q) begin
            dcnt_d = '0;
        end else if (dcnt_q >= len_i) begin
            filt_d = s2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + ONE;
        end
    end

    // Synchroniser and debounce state; idle bus level is high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            filt_q <= 1'b1;
            dcnt_q <= '0;
        end else begin
            s1_q   <= pad_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign filt_o = filt_q;
endmodule

module i2c_pin_conditioner #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i2c_enabled_i,
    input  logic [CNT_W-1:0] i2c_debounce_len_i,
    input  logic [CNT_W-1:0] i2c_scl_delay_len_i,
    input  logic [CNT_W-1:0] i2c_sda_delay_len_i,
    input  logic             i2c_scl_i,
    input  logic             i2c_sda_i,
    output logic             i2c_sda_o,
    input  logic             core_sda_i,
    output logic             scl_o,
    output logic             sda_o,
    output logic             scl_rise_o,
    output logic             scl_fall_o,
    output logic             start_o,
    output logic             stop_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Lane 0 is SCL, lane 1 is SDA.
    logic [1:0] pad, filt;
    assign pad = {i2c_sda_i, i2c_scl_i};

    for (genvar g = 0; g < 2; g++) begin : g_line
        i2c_pin_conditioner_line #(.CNT_W(CNT_W)) u_line (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .len_i  (i2c_debounce_len_i),
            .pad_i  (pad[g]),
            .filt_o (filt[g])
        );
    end

    logic             scl_q, scl_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             scl_prev_q, sda_prev_q;
    logic             rise_q, fall_q, start_q, stop_q;
    logic             rise_d, fall_d, start_d, stop_d;
    logic             osda_q, osda_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;

    // SCL delay toward the core; a change that reverts before expiry is dropped.
    always_comb begin
        scl_d  = scl_q;
        scnt_d = scnt_q;
        if (filt[0] == scl_q) begin
            scnt_d = '0;
        end else if (scnt_q >= i2c_scl_delay_len_i) begin
            scl_d  = filt[0];
            scnt_d = '0;
        end else begin
            scnt_d = scnt_q + ONE;
        end
    end

    // Strobes from previous vs current conditioned levels; START/STOP need SCL
    // high on both sides so a simultaneous SCL edge never qualifies.
    always_comb begin
        rise_d  = scl_q & ~scl_prev_q;
        fall_d  = ~scl_q & scl_prev_q;
        start_d = sda_prev_q & ~filt[1] & scl_prev_q & scl_q;
        stop_d  = ~sda_prev_q & filt[1] & scl_prev_q & scl_q;
    end

    // Pad SDA hold delay; disabling releases the pad on the next clock.
    always_comb begin
        osda_d = osda_q;
        ocnt_d = ocnt_q;
        if (!i2c_enabled_i) begin
            osda_d = 1'b1;
            ocnt_d = '0;
        end else if (core_sda_i == osda_q) begin
            ocnt_d = '0;
        end else if (ocnt_q >= i2c_sda_delay_len_i) begin
            osda_d = core_sda_i;
            ocnt_d = '0;
        end else begin
            ocnt_d = ocnt_q + ONE;
        end
    end

    // All conditioner state; reset abandons any pending change.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_q      <= 1'b1;
            scnt_q     <= '0;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            osda_q     <= 1'b1;
            ocnt_q     <= '0;
        end else begin
            scl_q      <= scl_d;
            scnt_q     <= scnt_d;
            scl_prev_q <= scl_q;
            sda_prev_q <= filt[1];
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            osda_q     <= osda_d;
            ocnt_q     <= ocnt_d;
        end
    end

    assign scl_o      = scl_q;
    assign sda_o      = filt[1];
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign i2c_sda_o  = osda_q;
endmodule

// File: tb/tb_i2c_pin_conditioner.sv
// Directed bench for i2c_pin_conditioner; expectations queued, then popped
// and asserted as the DUT responds.
module tb_i2c_pin_conditioner;
    logic       clk = 1'b0;
    logic       rst_ni, en;
    logic [7:0] deb, sdl, odl;
    logic       scl, sda, core;
    logic       i2c_sda_o, scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o;

    i2c_pin_conditioner #(.CNT_W(8)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .i2c_enabled_i       (en),
        .i2c_debounce_len_i  (deb),
        .i2c_scl_delay_len_i (sdl),
        .i2c_sda_delay_len_i (odl),
        .i2c_scl_i           (scl),
        .i2c_sda_i           (sda),
        .i2c_sda_o           (i2c_sda_o),
        .core_sda_i          (core),
        .scl_o               (scl_o),
        .sda_o               (sda_o),
        .scl_rise_o          (scl_rise_o),
        .scl_fall_o          (scl_fall_o),
        .start_o             (start_o),
        .stop_o              (stop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;
    sb_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Per-window observations; indices count posedges since the window opened.
    int n_scl, n_sda, n_out, n_rise, n_fall, n_start, n_stop;
    int t_scl, t_sda, t_out, t_rise, t_start, t_stop;
    int bad;

    task automatic expect_v(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Run n clocks and record changes/pulses on every output.
    task automatic watch(input int n);
        logic p_scl, p_sda, p_out;
        p_scl = scl_o; p_sda = sda_o; p_out = i2c_sda_o;
        n_scl = 0; n_sda = 0; n_out = 0; n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0;
        t_scl = -1; t_sda = -1; t_out = -1; t_rise = -1; t_start = -1; t_stop = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (scl_o !== p_scl) begin n_scl++; if (t_scl < 0) t_scl = i; end
            if (sda_o !== p_sda) begin n_sda++; if (t_sda < 0) t_sda = i; end
            if (i2c_sda_o !== p_out) begin n_out++; if (t_out < 0) t_out = i; end
            if (scl_rise_o === 1'b1) begin n_rise++; if (t_rise < 0) t_rise = i; end
            if (scl_fall_o === 1'b1) n_fall++;
            if (start_o === 1'b1) begin n_start++; if (t_start < 0) t_start = i; end
            if (stop_o === 1'b1) begin n_stop++; if (t_stop < 0) t_stop = i; end
            p_scl = scl_o; p_sda = sda_o; p_out = i2c_sda_o;
        end
    endtask

    initial begin
        rst_ni = 1'b0; en = 1'b1; deb = 8'd0; sdl = 8'd0; odl = 8'd0;
        scl = 1'b1; sda = 1'b1; core = 1'b1;

        // Reset held with pads toggling: outputs idle high, strobes quiet.
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            scl = i[0]; sda = ~i[0]; core = i[0];
            tick();
            if (!(scl_o === 1'b1 && sda_o === 1'b1 && i2c_sda_o === 1'b1 &&
                  scl_rise_o === 1'b0 && scl_fall_o === 1'b0 &&
                  start_o === 1'b0 && stop_o === 1'b0)) bad++;
        end
        expect_v("reset_hold_idle", 0);
        chk(bad);
        scl = 1'b1; sda = 1'b1; core = 1'b1;
        tick();
        rst_ni = 1'b1;
        expect_v("reset_release_strobes", 0);
        expect_v("reset_release_changes", 0);
        watch(10);
        chk(n_rise + n_fall + n_start + n_stop);
        chk(n_scl + n_sda + n_out);

        // Debounce length 4: 4-clock glitch suppressed.
        deb = 8'd4;
        sda = 1'b0;
        watch(4);
        expect_v("deb_glitch4_sda", 0);
        chk(n_sda);
        sda = 1'b1;
        watch(12);
        expect_v("deb_glitch4_sda_after", 0);
        chk(n_sda);

        // 5-clock glitch just exceeds the length and does propagate.
        sda = 1'b0;
        watch(5);
        expect_v("deb_glitch5_pre", 0);
        chk(n_sda);
        sda = 1'b1;
        watch(15);
        expect_v("deb_glitch5_fall_idx", 2);
        expect_v("deb_glitch5_changes", 2);
        chk(t_sda);
        chk(n_sda);

        // Stable low: sda_o falls 2 (sync) + 5 (debounce) clocks after the pad.
        sda = 1'b0;
        expect_v("deb_fall_latency", 7);
        expect_v("deb_start_idx", 8);
        watch(10);
        chk(t_sda);
        chk(t_start);
        sda = 1'b1;
        expect_v("deb_rise_latency", 7);
        expect_v("deb_stop_cnt", 1);
        watch(20);
        chk(t_sda);
        chk(n_stop);

        // START/STOP with zero lengths, SCL high.
        deb = 8'd0;
        sda = 1'b0;
        expect_v("start_sda_latency", 3);
        expect_v("start_idx", 4);
        expect_v("start_cnt", 1);
        expect_v("start_no_stop", 0);
        watch(8);
        chk(t_sda); chk(t_start); chk(n_start); chk(n_stop);
        sda = 1'b1;
        expect_v("stop_idx", 4);
        expect_v("stop_cnt", 1);
        expect_v("stop_no_start", 0);
        watch(8);
        chk(t_stop); chk(n_stop); chk(n_start);

        // SCL toggling with SDA stable: edge strobes only; delay 0 adds one clock.
        for (int k = 0; k < 3; k++) begin
            scl = 1'b0;
            expect_v("tog_fall_scl_idx", 4);
            expect_v("tog_fall_cnt", 1);
            expect_v("tog_fall_no_ss", 0);
            watch(6);
            chk(t_scl); chk(n_fall); chk(n_start + n_stop);
            scl = 1'b1;
            expect_v("tog_rise_idx", 5);
            expect_v("tog_rise_cnt", 1);
            expect_v("tog_rise_no_ss", 0);
            watch(6);
            chk(t_rise); chk(n_rise); chk(n_start + n_stop);
        end

        // Simultaneous conditioned edges: SCL rise with SDA fall -> no START.
        scl = 1'b0;
        watch(6);
        scl = 1'b1;
        tick();
        sda = 1'b0;
        expect_v("sim_scl_idx", 3);
        expect_v("sim_sda_idx", 3);
        expect_v("sim_rise_cnt", 1);
        expect_v("sim_no_start", 0);
        watch(8);
        chk(t_scl); chk(t_sda); chk(n_rise); chk(n_start);
        // SCL fall with SDA rise -> no STOP.
        scl = 1'b0;
        tick();
        sda = 1'b1;
        expect_v("sim2_fall_cnt", 1);
        expect_v("sim2_no_stop", 0);
        watch(8);
        chk(n_fall); chk(n_stop);
        scl = 1'b1;
        watch(8);

        // SCL delay 10: scl_o follows filt after 11 clocks (filt is 3 after pad).
        sdl = 8'd10;
        scl = 1'b0;
        expect_v("sdel_fall_idx", 14);
        expect_v("sdel_fall_cnt", 1);
        watch(20);
        chk(t_scl); chk(n_fall);
        scl = 1'b1;
        expect_v("sdel_rise_idx", 14);
        watch(20);
        chk(t_scl);
        scl = 1'b0;
        watch(16);
        // 6-clock high glitch is cancelled before the delay expires.
        scl = 1'b1;
        watch(6);
        expect_v("sdel_glitch_pre", 0);
        chk(n_scl);
        scl = 1'b0;
        expect_v("sdel_glitch_scl", 0);
        expect_v("sdel_glitch_rise", 0);
        watch(30);
        chk(n_scl); chk(n_rise);
        // Lowering the length below the running count fires on the next clock.
        scl = 1'b1;
        expect_v("sdel_lower_pre", 0);
        watch(8);
        chk(n_scl);
        sdl = 8'd2;
        expect_v("sdel_lower_idx", 1);
        watch(4);
        chk(t_scl);
        sdl = 8'd0;

        // SDA pad hold delay 3: drive low after 4 clocks.
        odl = 8'd3;
        core = 1'b0;
        expect_v("hold_drive_idx", 4);
        expect_v("hold_drive_cnt", 1);
        watch(8);
        chk(t_out); chk(n_out);
        en = 1'b0;
        expect_v("hold_disable_idx", 1);
        watch(4);
        chk(t_out);
        en = 1'b1;
        expect_v("hold_reenable_idx", 4);
        watch(8);
        chk(t_out);
        // 3-clock release request is dropped.
        core = 1'b1;
        watch(3);
        core = 1'b0;
        expect_v("hold_drop", 0);
        chk(n_out);
        watch(8);
        expect_v("hold_drop_after", 0);
        chk(n_out);
        core = 1'b1;
        expect_v("hold_release_idx", 4);
        watch(8);
        chk(t_out);

        // Reset while SCL and SDA-out changes are pending.
        sdl = 8'd10; odl = 8'd10;
        scl = 1'b0; core = 1'b0;
        expect_v("rstmid_pending_scl", 0);
        expect_v("rstmid_pending_out", 0);
        watch(6);
        chk(n_scl); chk(n_out);
        rst_ni = 1'b0; scl = 1'b1; core = 1'b1;
        tick();
        rst_ni = 1'b1;
        expect_v("rstmid_scl", 1);
        expect_v("rstmid_sda", 1);
        expect_v("rstmid_out", 1);
        chk(scl_o); chk(sda_o); chk(i2c_sda_o);
        expect_v("rstmid_no_late", 0);
        expect_v("rstmid_no_strobe", 0);
        watch(40);
        chk(n_scl + n_sda + n_out);
        chk(n_rise + n_fall + n_start + n_stop);

        expect_v("scoreboard_drained", 0);
        chk(sb.size() - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_pin_conditioner.md
Name: i2c_pin_conditioner

Overview:
- Pad-side front end for the I2C peripheral protocol engine.
- Synchronises and debounces raw SCL/SDA, then applies a programmable SCL delay toward the core.
- Emits one-cycle SCL edge and START/STOP strobes.
- Applies a programmable hold delay to the core's SDA drive before it reaches the pad.

Parameters:
CNT_W, 8, width of debounce/delay length inputs and internal counters

Ports:
clk_i  input  1  system clock
rst_ni  input  1  synchronous active-low reset
i2c_enabled_i  input  1  when 0, pad SDA output forced released (1)
i2c_debounce_len_i  input  CNT_W  debounce length in clocks
i2c_scl_delay_len_i  input  CNT_W  SCL delay toward core in clocks
i2c_sda_delay_len_i  input  CNT_W  SDA output hold delay in clocks
i2c_scl_i  input  1  raw SCL pad input
i2c_sda_i  input  1  raw SDA pad input
i2c_sda_o  output  1  SDA pad drive (0 = pull low, 1 = release)
core_sda_i  input  1  SDA drive requested by the protocol engine
scl_o  output  1  conditioned, delayed SCL to core
sda_o  output  1  conditioned SDA to core
scl_rise_o  output  1  one-cycle pulse on scl_o 0->1
scl_fall_o  output  1  one-cycle pulse on scl_o 1->0
start_o  output  1  one-cycle pulse: sda_o 1->0 while scl_o=1
stop_o  output  1  one-cycle pulse: sda_o 0->1 while scl_o=1

Behaviour:
- Reset (rst_ni=0 at posedge clk_i, synchronous):
  - Synchronisers, filtered values, scl_o, sda_o and i2c_sda_o all set to 1.
  - All counters cleared; all strobes 0.
  - Reset mid-transfer abandons any pending change.
- Synchroniser: two-flop chain per line; sync value = second flop.
- Debounce, independent per line, filt register plus counter dcnt:
  - sync==filt: dcnt<=0.
  - sync!=filt and dcnt>=debounce_len: filt<=sync, dcnt<=0.
  - Otherwise: dcnt<=dcnt+1.
  - Result: a stable change propagates to filt debounce_len+1 clocks after sync changes.
  - len=0 is a plain register.
  - A glitch of length <=debounce_len clocks is suppressed.
- sda_o = SDA filt directly.
- SCL delay, counter scnt:
  - scl_filt==scl_o: scnt<=0.
  - Else if scnt>=scl_delay_len: scl_o<=scl_filt, scnt<=0.
  - Else: scnt++.
  - scl_delay_len=0 adds one clock.
  - If scl_filt reverts before expiry, the pending change is cancelled.
- Length inputs are sampled every cycle. Lowering a length below the current count fires on the next clock (>= comparison); there is no wrap.
- Strobes, registered from the current and previous values of scl_o/sda_o (one clock after the change):
  - scl_rise_o / scl_fall_o on scl_o transitions.
  - start_o when sda_o falls and scl_o is 1 in both the previous and current cycle.
  - stop_o when sda_o rises under the same SCL condition.
  - Simultaneous SCL and SDA change: no start/stop; only the SCL edge strobe fires.
- SDA output delay, counter ocnt, target t = core_sda_i & i2c_enabled_i... but disable overrides:
  - i2c_enabled_i=0: i2c_sda_o<=1 next clock, ocnt<=0.
  - Else, core_sda_i==i2c_sda_o: ocnt<=0.
  - Else, ocnt>=sda_delay_len: i2c_sda_o<=core_sda_i, ocnt<=0.
  - Else: ocnt++.
  - Release and drive both delayed equally.
  - A core request that reverts before expiry is dropped.
- Counters saturate by construction: max count = len <= 2^CNT_W-1.

Test Plan:
- Reset: hold rst_ni=0 with pads toggling -> scl_o=sda_o=i2c_sda_o=1, all strobes 0. Release reset with pads high -> no strobes.
- Debounce: debounce_len=4; SDA low pulse of 4 clocks -> sda_o stays 1. SDA low for 10 clocks -> sda_o falls exactly 2+5=7 clocks after the pad edge.
- START/STOP: debounce_len=0, scl_delay_len=0, SCL held 1; SDA 1->0 -> single start_o pulse. SDA 0->1 -> single stop_o pulse. SCL toggling with SDA stable -> matching scl_rise_o/scl_fall_o pulses, no start/stop.
- SCL delay: scl_delay_len=10; SCL fall -> scl_o falls 11 clocks after scl_filt. A 6-clock SCL high glitch after debounce -> scl_o unchanged.
- SDA hold: sda_delay_len=3, enabled; core_sda_i 1->0 -> i2c_sda_o 0 after 4 clocks. Deassert i2c_enabled_i during low -> i2c_sda_o=1 next clock.
- Reset mid-operation: rst_ni=0 for 1 clock while scnt/ocnt pending -> all outputs 1 next clock, no late transition afterwards.
